param_sync_fifo: RTL and testbench
==================================

# param_sync_fifo

Parametrised single-clock FIFO: the next-generation data buffer behind the `wr_en`/`rd_en`/`data_in`/`data_out` bench interface, generalised in width and depth. Adds occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It also adds a selectable first-word-fall-through (FWFT) read mode. Sits between a producer and consumer in the same clock domain and is the primary DUT for the bench interface.

## Interface
- `DATA_W`, default 8, data word width (≥1).
- `DEPTH`, default 16, number of entries; power of two, ≥4.
- `AFULL_TH`, default `DEPTH-2`, `almost_full` asserted when count ≥ this.
- `AEMPTY_TH`, default 2, `almost_empty` asserted when count ≤ this.
- `FWFT`, default 0, 0 = standard registered read, 1 = first-word-fall-through.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write request.
- `data_in`  in  `DATA_W`  write data.
- `rd_en`  in  1  read request.
- `data_out`  out  `DATA_W`  read data.
- `full`  out  1  count == `DEPTH`.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ `AFULL_TH`.
- `almost_empty`  out  1  count ≤ `AEMPTY_TH`.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky: write attempted while full.
- `underflow`  out  1  sticky: read attempted while empty.
- `err_clr`  in  1  clears `overflow`/`underflow`.

## Operation
- Write accepted iff `wr_en && !full`; read accepted iff `rd_en && !empty`. Acceptance uses flags of the current cycle.
- Full and `wr_en` with `rd_en`: only the read is accepted. Empty and both asserted: only the write is accepted. No bypass in either case.
- Both accepted: count unchanged, both pointers advance.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0. Count is a separate register, +1/−1/0 per cycle.
- Flags are combinational compares on the registered `count`.
- `overflow` sets on `wr_en && full`; `underflow` sets on `rd_en && empty`. Both hold until `err_clr` or `reset`. If `err_clr` and a new error occur in the same cycle, the flag remains set.
- Rejected operations do not modify memory, pointers, count or `data_out`.
- Standard mode (`FWFT=0`): `data_out` is a register loaded from the head entry on an accepted read. It holds otherwise.
- FWFT mode (`FWFT=1`): `data_out` equals the head entry whenever `!empty`, and 0 when empty. An accepted read pops it.

## Timing
- Reset values: pointers 0, `count` 0, `empty` 1, `full` 0, `almost_empty` 1, `almost_full` 0, `overflow`/`underflow` 0, `data_out` 0. Memory contents are not cleared.
- Reset mid-operation: all stored data is discarded on the next edge; any concurrent `wr_en`/`rd_en` is ignored in that cycle.
- Write at edge N: `count`/`empty` update after edge N.
- Standard mode: read accepted at edge N gives `data_out` valid after edge N, i.e. 1-cycle latency. Minimum write-to-data is 2 edges.
- FWFT mode: a word written at edge N into an empty FIFO appears on `data_out` after edge N, i.e. 1-cycle write-to-data.
- Throughput is one write and one read per cycle sustained.

## Structure
- Package `fifo_pkg` holds:
  - helper function `cnt_w(depth)` returning `$clog2(depth)+1`;
  - mode constants `FIFO_STD=0` and `FIFO_FWFT=1`.
- Sub-module `fifo_mem`: `DEPTH`×`DATA_W` simple dual-port array, synchronous write, asynchronous read addressed by read pointer. The top level holds pointers, count, flags and output register.
- The bench interface is parametrised on `DATA_W` and carries the new flag and `err_clr` signals.

## Test plan
All scenarios use `DATA_W=8`, `DEPTH=16`.
- Fill/drain: write 0x00..0x0F, then read 16. `data_out` sequence is 0x00..0x0F. `full` is 1 exactly at count 16; `empty` returns to 1 after the last read.
- Thresholds: with defaults, `almost_full` rises when count goes 13→14 and `almost_empty` falls when count goes 2→3. Check both directions.
- Boundaries:
  - When full, assert `wr_en`+`rd_en`: count 16→15, `overflow`=1, no data lost.
  - When empty, assert `rd_en`+`wr_en` of 0xA5: count 0→1, `underflow`=1, 0xA5 later read correctly.
  - Assert `err_clr` alone: both flags go to 0.
- Wrap-around: 40 cycles of simultaneous write/read of an incrementing pattern at count 8. Pointers wrap ≥2 times, count stays 8, output sequence is exact.
- FWFT: write 0x3C to empty. `data_out`=0x3C one cycle later without `rd_en`; after `rd_en`, `data_out`=0 and `empty`=1.
- Reset mid-stream: reset at count 9 with `wr_en` high gives count 0, `empty`=1, `data_out`=0. A subsequent write/read of 0x77 returns 0x77.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Imported by the storage array and the top-level controller.
package fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a selectable standard-registered or first-word-fall-through read port.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2,
    parameter int unsigned FWFT      = FIFO_STD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_TH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] head_data;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !reset),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (head_data)
    );

    // Flags are pure decodes of the registered count.
    always_comb begin
        full         = (count_q == FULL_CNT);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AFULL_CNT);
        almost_empty = (count_q <= AEMPTY_CNT);
    end

    always_comb begin
        wr_acc   = wr_en && !full;
        rd_acc   = rd_en && !empty;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A new error wins over a simultaneous clear.
        overflow_d  = (wr_en && full) || (overflow_q && !err_clr);
        underflow_d = (rd_en && empty) || (underflow_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign data_out = empty ? '0 : head_data;
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= head_data;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    count_in_range: assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT);

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: standard and FWFT instances share stimulus and are
// compared against a queue-based model of the FIFO rules.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data_in;

    logic [7:0] s_dout, f_dout;
    logic [4:0] s_count, f_count;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [5:0] s_flags, f_flags;

    assign s_flags = {s_full, s_empty, s_af, s_ae, s_ov, s_un};
    assign f_flags = {f_full, f_empty, f_af, f_ae, f_ov, f_un};

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ov;
    logic       m_un;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (s_dout),
        .full         (s_full),
        .empty        (s_empty),
        .almost_full  (s_af),
        .almost_empty (s_ae),
        .count        (s_count),
        .overflow     (s_ov),
        .underflow    (s_un),
        .err_clr      (err_clr)
    );

    param_sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (f_dout),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .count        (f_count),
        .overflow     (f_ov),
        .underflow    (f_un),
        .err_clr      (err_clr)
    );

    function automatic logic [5:0] exp_flags();
        int n;
        n = mq.size();
        return {n == 16, n == 0, n >= 14, n <= 2, m_ov, m_un};
    endfunction

    function automatic logic [7:0] exp_fwft();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    // One clock of stimulus; the model follows the FIFO rules at the same edge.
    task automatic drive(input logic wr, input logic rd, input logic [7:0] din,
                         input logic clr, input logic rst);
        logic was_full, was_empty;
        wr_en = wr; rd_en = rd; data_in = din; err_clr = clr; reset = rst;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ov = 1'b0; m_un = 1'b0; m_dout = 8'h00;
        end else begin
            was_full  = (mq.size() == 16);
            was_empty = (mq.size() == 0);
            m_ov = (wr && was_full) || (m_ov && !clr);
            m_un = (rd && was_empty) || (m_un && !clr);
            if (rd && !was_empty) m_dout = mq.pop_front();
            if (wr && !was_full) mq.push_back(din);
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 0, 8'h00, 0, 1);
        drive(0, 0, 8'h00, 0, 1);
        checks++;
        if (s_count !== 5'd0 || f_count !== 5'd0) begin
            fails++; $display("FAIL reset count: got %0d/%0d expected 0", s_count, f_count);
        end
        checks++;
        if (s_flags !== 6'b010100 || f_flags !== 6'b010100) begin
            fails++; $display("FAIL reset flags: got %b/%b expected 010100", s_flags, f_flags);
        end
        checks++;
        if (s_dout !== 8'h00 || f_dout !== 8'h00) begin
            fails++; $display("FAIL reset data_out: got %h/%h expected 00", s_dout, f_dout);
        end
    endtask

    task automatic test_fill_drain();
        drive(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 32; i++) begin
            if (i < 16) drive(1, 0, 8'(i), 0, 0);
            else        drive(0, 1, 8'h00, 0, 0);
            checks++;
            if (s_count !== 5'(mq.size())) begin
                fails++; $display("FAIL fill count: got %0d expected %0d", s_count, mq.size());
            end
            checks++;
            if (s_flags !== exp_flags() || f_flags !== exp_flags()) begin
                fails++;
                $display("FAIL fill flags: got %b/%b expected %b", s_flags, f_flags, exp_flags());
            end
            checks++;
            if (f_dout !== exp_fwft()) begin
                fails++; $display("FAIL fill fwft data: got %h expected %h", f_dout, exp_fwft());
            end
            if (i >= 16) begin
                checks++;
                if (s_dout !== 8'(i - 16)) begin
                    fails++; $display("FAIL drain data: got %h expected %h", s_dout, 8'(i - 16));
                end
            end
        end
        checks++;
        if (s_empty !== 1'b1) begin
            fails++; $display("FAIL drain empty: got %b expected 1", s_empty);
        end
    endtask

    task automatic test_thresholds();
        drive(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 30; i++) begin
            if (i < 15) drive(1, 0, 8'(i + 8'h60), 0, 0);
            else        drive(0, 1, 8'h00, 0, 0);
            checks++;
            if (s_af !== (mq.size() >= 14) || s_ae !== (mq.size() <= 2)) begin
                fails++;
                $display("FAIL thresholds at count %0d: got af=%b ae=%b", mq.size(), s_af, s_ae);
            end
            checks++;
            if (s_dout !== m_dout) begin
                fails++; $display("FAIL thresholds data: got %h expected %h", s_dout, m_dout);
            end
        end
    endtask

    task automatic test_boundaries();
        drive(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 16; i++) drive(1, 0, 8'(i + 8'h10), 0, 0);
        drive(1, 1, 8'hEE, 0, 0);
        checks++;
        if (s_count !== 5'd15 || s_ov !== 1'b1 || s_dout !== 8'h10) begin
            fails++;
            $display("FAIL full wr+rd: got count=%0d ov=%b dout=%h expected 15 1 10",
                     s_count, s_ov, s_dout);
        end
        for (int i = 0; i < 15; i++) begin
            drive(0, 1, 8'h00, 0, 0);
            checks++;
            if (s_dout !== 8'(i + 8'h11)) begin
                fails++; $display("FAIL full drain: got %h expected %h", s_dout, 8'(i + 8'h11));
            end
        end
        drive(1, 1, 8'hA5, 0, 0);
        checks++;
        if (s_count !== 5'd1 || s_un !== 1'b1 || f_dout !== 8'hA5) begin
            fails++;
            $display("FAIL empty wr+rd: got count=%0d un=%b fwft=%h expected 1 1 a5",
                     s_count, s_un, f_dout);
        end
        drive(0, 1, 8'h00, 0, 0);
        checks++;
        if (s_dout !== 8'hA5) begin
            fails++; $display("FAIL empty wr+rd data: got %h expected a5", s_dout);
        end
        drive(0, 1, 8'h00, 1, 0);
        checks++;
        if (s_un !== 1'b1 || s_ov !== 1'b0) begin
            fails++; $display("FAIL clr+new error: got ov=%b un=%b expected 0 1", s_ov, s_un);
        end
        drive(0, 0, 8'h00, 1, 0);
        checks++;
        if (s_ov !== 1'b0 || s_un !== 1'b0 || f_un !== 1'b0) begin
            fails++; $display("FAIL err_clr: got ov=%b un=%b expected 0 0", s_ov, s_un);
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 8; i++) drive(1, 0, 8'(i), 0, 0);
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 8'(i + 8), 0, 0);
            checks++;
            if (s_count !== 5'd8 || s_dout !== 8'(i)) begin
                fails++;
                $display("FAIL wrap: got count=%0d dout=%h expected 8 %h", s_count, s_dout, 8'(i));
            end
            checks++;
            if (f_dout !== exp_fwft()) begin
                fails++; $display("FAIL wrap fwft: got %h expected %h", f_dout, exp_fwft());
            end
        end
    endtask

    task automatic test_fwft();
        drive(0, 0, 8'h00, 0, 1);
        drive(1, 0, 8'h3C, 0, 0);
        checks++;
        if (f_dout !== 8'h3C || s_dout !== 8'h00) begin
            fails++; $display("FAIL fwft write: got %h/%h expected 3c/00", f_dout, s_dout);
        end
        drive(0, 1, 8'h00, 0, 0);
        checks++;
        if (f_dout !== 8'h00 || f_empty !== 1'b1 || s_dout !== 8'h3C) begin
            fails++;
            $display("FAIL fwft pop: got fwft=%h empty=%b std=%h expected 00 1 3c",
                     f_dout, f_empty, s_dout);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 10; i++) drive(1, 0, 8'(i + 8'h40), 0, 0);
        drive(0, 1, 8'h00, 0, 0);
        drive(1, 0, 8'h99, 0, 1);
        checks++;
        if (s_count !== 5'd0 || s_empty !== 1'b1 || s_dout !== 8'h00 || f_dout !== 8'h00) begin
            fails++;
            $display("FAIL reset mid: got count=%0d empty=%b dout=%h/%h expected 0 1 00/00",
                     s_count, s_empty, s_dout, f_dout);
        end
        drive(1, 0, 8'h77, 0, 0);
        checks++;
        if (f_dout !== 8'h77) begin
            fails++; $display("FAIL reset mid fwft: got %h expected 77", f_dout);
        end
        drive(0, 1, 8'h00, 0, 0);
        checks++;
        if (s_dout !== 8'h77 || s_empty !== 1'b1) begin
            fails++; $display("FAIL reset mid read: got %h expected 77", s_dout);
        end
    endtask

    task automatic test_random();
        drive(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5), 8'($urandom),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
            checks++;
            if (s_count !== 5'(mq.size()) || f_count !== 5'(mq.size())) begin
                fails++; $display("FAIL random count: got %0d expected %0d", s_count, mq.size());
            end
            checks++;
            if (s_flags !== exp_flags() || f_flags !== exp_flags()) begin
                fails++;
                $display("FAIL random flags: got %b/%b expected %b", s_flags, f_flags, exp_flags());
            end
            checks++;
            if (s_dout !== m_dout) begin
                fails++; $display("FAIL random std data: got %h expected %h", s_dout, m_dout);
            end
            checks++;
            if (f_dout !== exp_fwft()) begin
                fails++; $display("FAIL random fwft data: got %h expected %h", f_dout, exp_fwft());
            end
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;
        m_ov = 1'b0; m_un = 1'b0; m_dout = 8'h00;
        test_reset();
        test_fill_drain();
        test_thresholds();
        test_boundaries();
        test_wrap();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
